// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: shared constants for the MIPS debug unit.
//   Frame layout from MicroBlaze: {code[6], valid[1], addr_type[9], address[16]}
//   Response layout to MicroBlaze: {code[6], ready[1], 9'b0, payload[16]}
package mips_debug_pkg;

  localparam int NB_CONTROL_FRAME = 32;
  localparam int NB_CODE          = 6;
  localparam int NB_ADDR_TYPE     = 9;
  localparam int NB_ADDR_DATA     = 16;
  localparam int NB_INSTR_ADDR    = 9;
  localparam int NB_DATA          = 32;

  // frame field offsets
  localparam int ADDR_LSB  = 0;
  localparam int TYPE_LSB  = 16;
  localparam int VALID_BIT = 25;
  localparam int CODE_LSB  = 26;

  // command / response codes
  localparam logic [NB_CODE-1:0] CODE_START          = 6'b000001;
  localparam logic [NB_CODE-1:0] CODE_RESET          = 6'b000010;
  localparam logic [NB_CODE-1:0] CODE_REQ_DATA       = 6'b000011;
  localparam logic [NB_CODE-1:0] CODE_LOAD_INSTR_LSB = 6'b000100;
  localparam logic [NB_CODE-1:0] CODE_LOAD_INSTR_MSB = 6'b000101;
  localparam logic [NB_CODE-1:0] CODE_MODE_GET       = 6'b001000;
  localparam logic [NB_CODE-1:0] CODE_MODE_SET_CONT  = 6'b001001;
  localparam logic [NB_CODE-1:0] CODE_MODE_SET_STEP  = 6'b001010;
  localparam logic [NB_CODE-1:0] CODE_STEP           = 6'b100000;
  localparam logic [NB_CODE-1:0] CODE_GOT_DATA       = 6'b100100;
  localparam logic [NB_CODE-1:0] CODE_GIB_DATA       = 6'b100101;
  localparam logic [NB_CODE-1:0] CODE_ERR            = 6'b111111;

  // one-hot read-mux selectors carried in addr_type
  localparam logic [NB_ADDR_TYPE-1:0] REQ_REG    = 9'b000000001;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_DMEM   = 9'b000000010;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_PC     = 9'b000000100;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_IF_ID  = 9'b000001000;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_ID_EX  = 9'b000010000;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_EX_MEM = 9'b000100000;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_MEM_WB = 9'b001000000;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_IMEM   = 9'b010000000;
  localparam logic [NB_ADDR_TYPE-1:0] REQ_CYCLES = 9'b100000000;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_CONT, S_RUN_STEP, S_HALTED, S_RD_WAIT, S_RD_LO, S_RD_HI
  } state_t;

  function automatic logic [NB_CONTROL_FRAME-1:0] mk_resp(
    input logic [NB_CODE-1:0] code, input logic ready, input logic [NB_ADDR_DATA-1:0] payload);
    return {code, ready, 9'b0, payload};
  endfunction

endpackage

// File: rtl/mips_debug_unit_if.sv
// mips_debug_unit_if: MicroBlaze frame link, pipeline control, instruction
// memory write port and debug read-mux port of the debug unit.
//   master: drives frame, halt and read data (MicroBlaze / pipeline side)
//   slave : the debug unit
interface mips_debug_unit_if;
  import mips_debug_pkg::*;

  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze;
  logic                        i_halt;
  logic [NB_DATA-1:0]          i_read_data;
  logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze;
  logic                        o_pipe_enable;
  logic                        o_pipe_reset;
  logic                        o_instr_we;
  logic [NB_INSTR_ADDR-1:0]    o_instr_addr;
  logic [NB_DATA-1:0]          o_instr_data;
  logic [NB_ADDR_TYPE-1:0]     o_read_type;
  logic [NB_ADDR_DATA-1:0]     o_read_addr;
  logic                        o_mode_step;

  modport master (
    output i_frame_from_blaze, i_halt, i_read_data,
    input  o_frame_to_blaze, o_pipe_enable, o_pipe_reset, o_instr_we, o_instr_addr,
           o_instr_data, o_read_type, o_read_addr, o_mode_step
  );

  modport slave (
    input  i_frame_from_blaze, i_halt, i_read_data,
    output o_frame_to_blaze, o_pipe_enable, o_pipe_reset, o_instr_we, o_instr_addr,
           o_instr_data, o_read_type, o_read_addr, o_mode_step
  );
endinterface

// File: rtl/mips_debug_unit_cmd_sync.sv
// debug_cmd_sync: registers the incoming frame and edge-detects its valid bit
// so a frame held valid for many cycles produces a single cmd_strobe.
//   frame      : raw frame from MicroBlaze
//   cmd_strobe : one cycle on the first registered cycle of a valid frame
//   cmd_code / cmd_type / cmd_addr : fields of the registered frame
module debug_cmd_sync
  import mips_debug_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] frame,
  output logic                        cmd_strobe,
  output logic [NB_CODE-1:0]          cmd_code,
  output logic [NB_ADDR_TYPE-1:0]     cmd_type,
  output logic [NB_ADDR_DATA-1:0]     cmd_addr
);
  logic [NB_CONTROL_FRAME-1:0] frame_q;
  logic                        valid_qq;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      frame_q  <= '0;
      valid_qq <= 1'b0;
    end else begin
      frame_q  <= frame;
      valid_qq <= frame_q[VALID_BIT];
    end
  end

  assign cmd_strobe = frame_q[VALID_BIT] & ~valid_qq;
  assign cmd_code   = frame_q[CODE_LSB +: NB_CODE];
  assign cmd_type   = frame_q[TYPE_LSB +: NB_ADDR_TYPE];
  assign cmd_addr   = frame_q[ADDR_LSB +: NB_ADDR_DATA];
endmodule

// File: rtl/mips_debug_unit.sv
// mips_debug_unit: command sequencer between the MicroBlaze frame link and the
// MIPS pipeline. Decodes frames, drives pipeline reset/enable/step, writes
// instruction memory in 16-bit halves and returns 32-bit debug words in two
// 16-bit halves.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   dbg (slave)      : frame link, pipeline control, imem write, read-mux port
// All outputs are registered: an action shows two edges after the frame is
// first sampled.
module mips_debug_unit
  import mips_debug_pkg::*;
(
  input logic              i_clock,
  input logic              i_reset,
  mips_debug_unit_if.slave dbg
);
  logic                      cmd_strobe;
  logic [NB_CODE-1:0]        cmd_code;
  logic [NB_ADDR_TYPE-1:0]   cmd_type;
  logic [NB_ADDR_DATA-1:0]   cmd_addr;

  state_t                      state_q, state_n, ret_q, ret_n;
  logic                        mode_q, mode_n;
  logic [NB_ADDR_DATA-1:0]     lo_q, lo_n;
  logic                        lo_valid_q, lo_valid_n;
  logic [NB_INSTR_ADDR-1:0]    waddr_q, waddr_n, iaddr_q, iaddr_n;
  logic [NB_DATA-1:0]          shadow_q, shadow_n, idata_q, idata_n;
  logic [NB_CONTROL_FRAME-1:0] resp_q, resp_n;
  logic [NB_ADDR_TYPE-1:0]     rtype_q, rtype_n;
  logic [NB_ADDR_DATA-1:0]     raddr_q, raddr_n;
  logic                        en_q, en_n, prst_q, prst_n, we_q, we_n;
  logic                        step_pulse, err, idle_or_halted;

  debug_cmd_sync u_sync (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .frame      (dbg.i_frame_from_blaze),
    .cmd_strobe (cmd_strobe),
    .cmd_code   (cmd_code),
    .cmd_type   (cmd_type),
    .cmd_addr   (cmd_addr)
  );

  assign idle_or_halted = (state_q == S_IDLE) || (state_q == S_HALTED);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;  ret_q <= S_IDLE;  mode_q <= 1'b0;
      lo_q <= '0;  lo_valid_q <= 1'b0;  waddr_q <= '0;  shadow_q <= '0;
      resp_q <= '0;  iaddr_q <= '0;  idata_q <= '0;  rtype_q <= '0;  raddr_q <= '0;
      en_q <= 1'b0;  prst_q <= 1'b0;  we_q <= 1'b0;
    end else begin
      state_q <= state_n;  ret_q <= ret_n;  mode_q <= mode_n;
      lo_q <= lo_n;  lo_valid_q <= lo_valid_n;  waddr_q <= waddr_n;  shadow_q <= shadow_n;
      resp_q <= resp_n;  iaddr_q <= iaddr_n;  idata_q <= idata_n;  rtype_q <= rtype_n;
      raddr_q <= raddr_n;  en_q <= en_n;  prst_q <= prst_n;  we_q <= we_n;
    end
  end

  always_comb begin
    state_n = state_q;  ret_n = ret_q;  mode_n = mode_q;
    lo_n = lo_q;  lo_valid_n = lo_valid_q;  waddr_n = waddr_q;  shadow_n = shadow_q;
    resp_n = resp_q;  iaddr_n = iaddr_q;  idata_n = idata_q;
    rtype_n = rtype_q;  raddr_n = raddr_q;
    prst_n = 1'b0;  we_n = 1'b0;  step_pulse = 1'b0;  err = 1'b0;

    if (cmd_strobe && cmd_code == CODE_RESET) begin
      // RESET wins over everything, including a pending halt or readout
      state_n = S_IDLE;
      prst_n  = 1'b1;
      resp_n  = mk_resp(CODE_RESET, 1'b1, '0);
    end else if (state_q == S_RD_WAIT) begin
      // read mux has had one cycle to settle on rtype_q/raddr_q; a new strobe
      // cannot land here because valid must drop between frames
      shadow_n = dbg.i_read_data;
      state_n  = S_RD_LO;
      resp_n   = mk_resp(CODE_REQ_DATA, 1'b1, dbg.i_read_data[15:0]);
    end else if (cmd_strobe) begin
      resp_n = mk_resp(cmd_code, 1'b1, '0);
      case (cmd_code)
        CODE_START:
          if (state_q == S_IDLE) state_n = mode_q ? S_RUN_STEP : S_RUN_CONT;
          else err = 1'b1;
        CODE_STEP:
          if (state_q == S_RUN_STEP) step_pulse = 1'b1;
          else err = 1'b1;
        CODE_MODE_GET:
          resp_n = mk_resp(CODE_MODE_GET, 1'b1, {15'b0, mode_q});
        CODE_MODE_SET_CONT, CODE_MODE_SET_STEP:
          if (idle_or_halted) mode_n = (cmd_code == CODE_MODE_SET_STEP);
          else err = 1'b1;
        CODE_LOAD_INSTR_LSB:
          if (idle_or_halted) begin
            lo_n = cmd_addr;  waddr_n = cmd_type;  lo_valid_n = 1'b1;
          end else err = 1'b1;
        CODE_LOAD_INSTR_MSB:
          if (idle_or_halted && lo_valid_q) begin
            idata_n = {cmd_addr, lo_q};  iaddr_n = waddr_q;
            we_n = 1'b1;  lo_valid_n = 1'b0;
          end else err = 1'b1;
        CODE_REQ_DATA:
          if (idle_or_halted || state_q == S_RUN_STEP) begin
            rtype_n = cmd_type;  raddr_n = cmd_addr;
            ret_n = state_q;  state_n = S_RD_WAIT;
            resp_n = resp_q;  // answer is produced once the data is captured
          end else err = 1'b1;
        CODE_GIB_DATA:
          if (state_q == S_RD_LO) begin
            state_n = S_RD_HI;
            resp_n  = mk_resp(CODE_GIB_DATA, 1'b1, shadow_q[31:16]);
          end else err = 1'b1;
        CODE_GOT_DATA:
          if (state_q == S_RD_LO || state_q == S_RD_HI) begin
            state_n = ret_q;
            resp_n  = mk_resp(CODE_GOT_DATA, 1'b0, '0);
          end else err = 1'b1;
        default: err = 1'b1;
      endcase
      if (err) resp_n = mk_resp(CODE_ERR, 1'b1, {10'b0, cmd_code});
    end else if (dbg.i_halt && (state_q == S_RUN_CONT || state_q == S_RUN_STEP)) begin
      // a step pulse already on the output completes on its own
      state_n = S_HALTED;
    end

    en_n = (state_n == S_RUN_CONT) | step_pulse;
  end

  assign dbg.o_frame_to_blaze = resp_q;
  assign dbg.o_pipe_enable    = en_q;
  assign dbg.o_pipe_reset     = prst_q;
  assign dbg.o_instr_we       = we_q;
  assign dbg.o_instr_addr     = iaddr_q;
  assign dbg.o_instr_data     = idata_q;
  assign dbg.o_read_type      = rtype_q;
  assign dbg.o_read_addr      = raddr_q;
  assign dbg.o_mode_step      = mode_q;
endmodule
